sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Shares the single 512KB external SRAM (18-bit word address, 16-bit data) between two requesters: the host port (TI-99/4A CPU cycles decoded by the memory interface) and an aux port (loader/debug or future GROM/VDP emulation). Fixed host priority with a starvation guard for aux. Sequences RAMCS/RAMOE/RAMWE and the data-pin direction with parameterised wait counts. All SRAM pins are driven from registers.

Parameters:
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width
READ_WAIT, 2, cycles OE held low before read data capture (min 1)
WRITE_WAIT, 2, cycles WE held low (min 1)
AUX_MAX_DEFER, 4, consecutive host grants allowed while aux is pending before aux is forced

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
host_req  in  1  level request; held until host_ack seen
host_we  in  1  1=write, 0=read; sampled at grant
host_addr  in  ADDR_W  word address; sampled at grant
host_wdata  in  DATA_W  write data; sampled at grant
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  read data; held until next host read completes
aux_req, aux_we, aux_addr, aux_wdata, aux_ack, aux_rdata  same as host_* for aux port
sram_addr  out  ADDR_W  SRAM address pins
sram_dout  out  DATA_W  data to SRAM pins
sram_dout_en  out  1  1=FPGA drives data pins
sram_din  in  DATA_W  data from SRAM pins
ram_cs_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active low
owner_aux  out  1  0=host owns current/last cycle, 1=aux (debug)
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (async): state IDLE; cs_n/oe_n/we_n=1; dout_en=0; sram_addr, sram_dout, both rdata=0; acks=0; owner_aux=0; defer count=0. Reset mid-write deasserts WE immediately.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE: if any req: choose winner, latch addr/we/wdata, set owner_aux, cs_n=0. Read -> RD with oe_n=0. Write -> WR_SETUP with dout_en=1, we_n=1. No req: stay, strobes inactive.
- Arbitration: host wins ties unless defer==AUX_MAX_DEFER, then aux wins. Defer increments on each host grant while aux_req=1; clears on aux grant or when aux_req=0 in IDLE; saturates.
- RD: stays READ_WAIT cycles (counter); on last cycle sram_din captured into owner's rdata; -> ACK.
- WR_SETUP: 1 cycle, addr/data stable, we_n=1 -> WR_PULSE.
- WR_PULSE: we_n=0 for WRITE_WAIT cycles -> WR_HOLD.
- WR_HOLD: we_n=1, cs_n=0, data still driven 1 cycle -> ACK.
- ACK: owner's ack=1 for exactly one cycle; cs_n/oe_n/we_n=1, dout_en=0 -> IDLE.
- Latency (cycle 0 = IDLE cycle sampling req): read ack at cycle READ_WAIT+1; write ack at cycle WRITE_WAIT+3. Back-to-back: next grant earliest cycle after ACK.
- Requester must drop req on the edge it sees ack; req still high in next IDLE = new transaction.
- Req dropped mid-transaction: transaction completes, ack still pulsed. Input changes after grant ignored.
- dout_en and oe_n never both active; we_n low only while dout_en=1 and cs_n=0.
- Non-owner rdata unchanged by other port's reads.

Test Plan:
- Host read addr 0x0A000, sram_din=0x1234, READ_WAIT=2 -> oe_n low cycles 1-2, host_ack cycle 3, host_rdata=0x1234, aux_rdata=0.
- Aux write addr 0x3FFFF data 0xBEEF, WRITE_WAIT=2 -> dout_en 1 cycles 1-4, we_n low cycles 2-3 only, aux_ack cycle 5, sram_dout=0xBEEF.
- Both req every cycle, AUX_MAX_DEFER=4 -> grant order H,H,H,H,A,H,H,H,H,A; no ack to wrong port.
- Host drops req in middle of RD -> cycle completes, one host_ack pulse, return to IDLE, no second grant.
- Assert reset during WR_PULSE -> we_n=1, dout_en=0, cs_n=1 same cycle; no ack; next host read after reset runs normally.
- Host holds req one extra cycle after ack -> second identical read starts; check busy and strobe sequence repeat.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external asynchronous SRAM between a host port and
// an aux port. The host has fixed priority, and a deferral counter forces an aux
// grant after AUX_MAX_DEFER host grants while aux is waiting. Every SRAM pin is
// driven straight from a register.
module sram_arbiter #(
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned READ_WAIT     = 2,
    parameter int unsigned WRITE_WAIT    = 2,
    parameter int unsigned AUX_MAX_DEFER = 4
) (
    input  logic              clk,
    input  logic              reset,
    // host port
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    // aux port
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              ram_cs_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    // status
    output logic              owner_aux,
    output logic              busy
);

    localparam int unsigned WAIT_MAX = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int unsigned CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int unsigned DEF_W    = (AUX_MAX_DEFER > 0) ? $clog2(AUX_MAX_DEFER + 1) : 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);
    localparam logic [DEF_W-1:0] DEF_MAX = DEF_W'(AUX_MAX_DEFER);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        ACK
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEF_W-1:0]  defer_q, defer_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_en_q, dout_en_d;
    logic              cs_n_q, cs_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              host_ack_q, host_ack_d;
    logic              aux_ack_q, aux_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

    // Arbitration outcome for the current IDLE cycle
    logic              pick_aux;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Select the winning requester: host unless aux has been deferred to the limit
    always_comb begin
        pick_aux  = aux_req && (!host_req || (defer_q == DEF_MAX));
        sel_we    = pick_aux ? aux_we    : host_we;
        sel_addr  = pick_aux ? aux_addr  : host_addr;
        sel_wdata = pick_aux ? aux_wdata : host_wdata;
    end

    // Next-state and registered-output logic of the SRAM cycle sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        defer_d      = defer_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        dout_en_d    = dout_en_q;
        cs_n_d       = cs_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        host_ack_d   = 1'b0;
        aux_ack_d    = 1'b0;
        host_rdata_d = host_rdata_q;
        aux_rdata_d  = aux_rdata_q;

        unique case (state_q)
            IDLE: begin
                cs_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                we_n_d    = 1'b1;
                dout_en_d = 1'b0;
                if (!aux_req) begin
                    defer_d = '0;
                end
                if (host_req || aux_req) begin
                    owner_d = pick_aux;
                    addr_d  = sel_addr;
                    cs_n_d  = 1'b0;
                    if (pick_aux) begin
                        defer_d = '0;
                    end else if (aux_req && (defer_q != DEF_MAX)) begin
                        defer_d = defer_q + 1'b1;
                    end
                    if (sel_we) begin
                        dout_d    = sel_wdata;
                        dout_en_d = 1'b1;
                        state_d   = WR_SETUP;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_LOAD;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        aux_rdata_d = sram_din;
                        aux_ack_d   = 1'b1;
                    end else begin
                        host_rdata_d = sram_din;
                        host_ack_d   = 1'b1;
                    end
                    cs_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WR_LOAD;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: begin
                if (owner_q) begin
                    aux_ack_d = 1'b1;
                end else begin
                    host_ack_d = 1'b1;
                end
                cs_n_d    = 1'b1;
                dout_en_d = 1'b0;
                state_d   = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pin registers; async reset releases the bus immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            defer_q      <= '0;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            dout_en_q    <= 1'b0;
            cs_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            host_ack_q   <= 1'b0;
            aux_ack_q    <= 1'b0;
            host_rdata_q <= '0;
            aux_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            defer_q      <= defer_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            dout_en_q    <= dout_en_d;
            cs_n_q       <= cs_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            host_ack_q   <= host_ack_d;
            aux_ack_q    <= aux_ack_d;
            host_rdata_q <= host_rdata_d;
            aux_rdata_q  <= aux_rdata_d;
        end
    end

    assign sram_addr    = addr_q;
    assign sram_dout    = dout_q;
    assign sram_dout_en = dout_en_q;
    assign ram_cs_n     = cs_n_q;
    assign ram_oe_n     = oe_n_q;
    assign ram_we_n     = we_n_q;
    assign host_ack     = host_ack_q;
    assign aux_ack      = aux_ack_q;
    assign host_rdata   = host_rdata_q;
    assign aux_rdata    = aux_rdata_q;
    assign owner_aux    = owner_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed scenarios followed by random request
// traffic, checked cycle by cycle against a transaction-level reference model.
module tb_sram_arbiter;

    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int RW   = 2;
    localparam int WW   = 2;
    localparam int MAXD = 4;

    logic          clk;
    logic          reset;
    logic          host_req, host_we, host_ack;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          aux_req, aux_we, aux_ack;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata, aux_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout, sram_din;
    logic          sram_dout_en, ram_cs_n, ram_oe_n, ram_we_n;
    logic          owner_aux, busy;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW), .WRITE_WAIT(WW), .AUX_MAX_DEFER(MAXD)
    ) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_ack(aux_ack), .aux_rdata(aux_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .owner_aux(owner_aux), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents: the device array (written only through the pins) and
    // the reference array (written at transaction level). Unwritten words
    // hold a fixed address-derived pattern in both.
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[17:16], 14'h0A5C};
    endfunction

    function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return pat(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pat(a);
    endfunction

    // SRAM device: drives data while selected and output-enabled, stores on WE low
    initial begin
        sram_din = '1;
        forever begin
            @(negedge clk);
            sram_din = (!ram_cs_n && !ram_oe_n) ? dev_rd(sram_addr) : 16'hFFFF;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!reset && !ram_cs_n && !ram_we_n && sram_dout_en)
                dev_mem[sram_addr] = sram_dout;
        end
    end

    // Reference model: a transaction occupies offsets 1..len after its grant cycle;
    // reads hold OE for RW cycles and ack at RW+1, writes drive data for
    // WW+2 cycles with WE low at offsets 2..WW+1 and ack at WW+3.
    bit            m_busy, m_own, m_we, act, e_ack;
    int            m_t, m_len, m_def;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, e_hrd, e_ard;
    logic [3:0]    e_pins;

    initial begin
        m_busy = 0; m_own = 0; m_we = 0; m_t = 0; m_len = 0; m_def = 0;
        m_addr = '0; m_wdata = '0; e_hrd = '0; e_ard = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_busy = 0; m_own = 0; m_def = 0; e_hrd = '0; e_ard = '0;
                check_eq("rst_pins", {ram_cs_n, ram_oe_n, ram_we_n, sram_dout_en,
                                      host_ack, aux_ack, owner_aux, busy}, 8'b1110_0000);
                check_eq("rst_rdata", {host_rdata, aux_rdata}, '0);
                check_eq("rst_addr", sram_addr, '0);
                check_eq("rst_dout", sram_dout, '0);
            end else begin
                act    = m_busy && (m_t < m_len);
                e_ack  = m_busy && (m_t == m_len);
                e_pins = {~act, ~(act && !m_we),
                          ~(act && m_we && m_t >= 2 && m_t <= WW + 1), act && m_we};
                check_eq("strobes", {ram_cs_n, ram_oe_n, ram_we_n, sram_dout_en}, e_pins);
                check_eq("acks", {host_ack, aux_ack}, {e_ack && !m_own, e_ack && m_own});
                check_eq("busy", busy, m_busy);
                check_eq("owner", owner_aux, m_own);
                check_eq("host_rdata", host_rdata, e_hrd);
                check_eq("aux_rdata", aux_rdata, e_ard);
                if (act) check_eq("sram_addr", sram_addr, m_addr);
                if (act && m_we) check_eq("sram_dout", sram_dout, m_wdata);

                if (m_busy) begin
                    if (m_t == m_len) begin
                        m_busy = 0;
                    end else begin
                        m_t++;
                        if (m_t == m_len) begin
                            if (m_we) ref_mem[m_addr] = m_wdata;
                            else if (m_own) e_ard = ref_rd(m_addr);
                            else e_hrd = ref_rd(m_addr);
                        end
                    end
                end else begin
                    if (!aux_req) m_def = 0;
                    if (host_req || aux_req) begin
                        m_own = aux_req && (!host_req || m_def == MAXD);
                        if (m_own) m_def = 0;
                        else if (aux_req && m_def < MAXD) m_def++;
                        m_we    = m_own ? aux_we : host_we;
                        m_addr  = m_own ? aux_addr : host_addr;
                        m_wdata = m_own ? aux_wdata : host_wdata;
                        m_len   = m_we ? WW + 3 : RW + 1;
                        m_t     = 1;
                        m_busy  = 1;
                    end
                end
            end
        end
    end

    task automatic wait_ack(input bit aux, input int budget, output int lat);
        string tag;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((aux ? aux_ack : host_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
        tag = aux ? "aux_ack_wait" : "host_ack_wait";
        check_eq(tag, lat >= 0, 1);
    endtask

    function automatic logic next_req(input logic cur, input logic acked);
        if (cur && acked) return ($urandom_range(0, 3) == 0);
        if (cur) return ($urandom_range(0, 15) != 0);
        return ($urandom_range(0, 2) == 0);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return '1;
            1:       return '0;
            default: return 18'h00100 + 18'($urandom_range(0, 7));
        endcase
    endfunction

    int         lat, hcnt, n;
    logic [9:0] order;
    logic       hs, as;

    initial begin
        reset = 1'b1;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
        dev_mem[18'h0A000] = 16'h1234;
        ref_mem[18'h0A000] = 16'h1234;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Host read with latency and data checks
        host_we = 0; host_addr = 18'h0A000; host_req = 1;
        wait_ack(0, 20, lat);
        check_eq("rd_latency", lat, RW + 1);
        check_eq("rd_data", host_rdata, 16'h1234);
        check_eq("rd_aux_rdata", aux_rdata, '0);
        @(posedge clk); #1 host_req = 0; host_addr = 18'h12345;
        @(posedge clk); #1;

        // Aux write at the top address
        aux_we = 1; aux_addr = 18'h3FFFF; aux_wdata = 16'hBEEF; aux_req = 1;
        wait_ack(1, 20, lat);
        check_eq("wr_latency", lat, WW + 3);
        check_eq("wr_dout", sram_dout, 16'hBEEF);
        check_eq("wr_device", dev_rd(18'h3FFFF), 16'hBEEF);
        @(posedge clk); #1 aux_req = 0;
        @(posedge clk); #1;

        // Both ports requesting continuously: aux forced every fifth grant
        host_we = 0; host_addr = 18'h00101; aux_we = 0; aux_addr = 18'h3FFFF;
        host_req = 1; aux_req = 1;
        order = '0; n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            @(negedge clk);
            if (host_ack) begin order[n] = 1'b0; n++; end
            else if (aux_ack) begin order[n] = 1'b1; n++; end
        end
        check_eq("grant_count", n, 10);
        check_eq("grant_order", order, 10'b10_0001_0000);
        @(posedge clk); #1 host_req = 0; aux_req = 0;

        // Host drops request during RD: exactly one ack
        @(posedge clk); #1 host_we = 0; host_addr = 18'h00105; host_req = 1;
        @(posedge clk); #1 host_req = 0;
        hcnt = 0;
        repeat (10) begin @(negedge clk); if (host_ack) hcnt++; end
        check_eq("drop_ack_count", hcnt, 1);
        check_eq("drop_idle", busy, 0);

        // Reset during the write pulse releases the bus at once
        @(posedge clk); #1 host_we = 1; host_addr = 18'h2AAAA; host_wdata = 16'h5555; host_req = 1;
        @(posedge clk);
        @(posedge clk); #1;
        check_eq("pre_rst_we", ram_we_n, 0);
        reset = 1'b1;
        #1 check_eq("rst_mid_wr", {ram_we_n, sram_dout_en, ram_cs_n, host_ack}, 4'b1010);
        host_req = 0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 host_we = 0; host_addr = 18'h00102; host_req = 1;
        wait_ack(0, 20, lat);
        check_eq("post_rst_latency", lat, RW + 1);
        check_eq("post_rst_data", host_rdata, pat(18'h00102));

        // Request held one cycle past ack starts a second identical read
        @(posedge clk); #1;
        @(posedge clk); #1 host_req = 0;
        check_eq("repeat_busy", busy, 1);
        hcnt = 0;
        repeat (10) begin @(negedge clk); if (host_ack) hcnt++; end
        check_eq("repeat_ack_count", hcnt, 1);

        // Random traffic on both ports
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs = host_ack;
            as = aux_ack;
            @(posedge clk); #1;
            host_req   = next_req(host_req, hs);
            aux_req    = next_req(aux_req, as);
            host_we    = 1'($urandom_range(0, 1));
            aux_we     = 1'($urandom_range(0, 1));
            host_addr  = rand_addr();
            aux_addr   = rand_addr();
            host_wdata = 16'($urandom);
            aux_wdata  = 16'($urandom);
        end
        host_req = 0; aux_req = 0;
        repeat (20) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
